// File: rtl/pc_fetch_if.sv
// Fetch-sequencer bus: control inputs from decode/branch logic plus the
// instruction-memory handshake and program-counter outputs.
interface pc_fetch_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic            branch_taken;
  logic [XLEN-1:0] branch_target;
  logic            jump;
  logic [XLEN-1:0] jump_target;
  logic            trap;
  logic            mret;
  logic            imem_ready;
  logic            imem_req;
  logic [XLEN-1:0] PC;
  logic [XLEN-1:0] PC_next;
  logic [XLEN-1:0] epc;
  logic            fetch_valid;
  logic            misaligned;

  // The sequencer itself
  modport slave (
    input  stall, branch_taken, branch_target, jump, jump_target,
           trap, mret, imem_ready,
    output imem_req, PC, PC_next, epc, fetch_valid, misaligned
  );

  // Core/memory side driving the sequencer
  modport master (
    output stall, branch_taken, branch_target, jump, jump_target,
           trap, mret, imem_ready,
    input  imem_req, PC, PC_next, epc, fetch_valid, misaligned
  );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Program-counter owner and instruction-fetch sequencer.
// BOOT -> FETCH after reset; FETCH commits when memory is ready and the core
// is not stalled; STALL holds the PC; TRAP is a one-cycle bubble after a
// trap or a misaligned redirect.
module pc_fetch_sequencer #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100)
) (
  input  logic      clk,
  input  logic      rst,
  pc_fetch_if.slave bus
);

  typedef enum logic [1:0] {BOOT, FETCH, STALL, TRAP} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc_q, epc_q;
  logic            mis_q;

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] sel;
  logic            redirect;
  logic            commit;
  logic            bad_target;
  logic            take_trap;

  // Sequential PC+4 wraps naturally at the top of the address space
  assign pc_plus4 = pc_q + XLEN'(4);

  // Next-PC priority mux: trap > mret > jump > branch > sequential
  always_comb begin
    sel      = pc_plus4;
    redirect = 1'b0;
    if (bus.trap) begin
      sel = TRAP_VECTOR;
    end else if (bus.mret) begin
      sel      = epc_q;
      redirect = 1'b1;
    end else if (bus.jump) begin
      sel      = bus.jump_target;
      redirect = 1'b1;
    end else if (bus.branch_taken) begin
      sel      = bus.branch_target;
      redirect = 1'b1;
    end
  end

  // A commit retires the instruction at PC; control inputs matter only here
  assign commit     = (state == FETCH) && bus.imem_ready && !bus.stall;
  assign bad_target = redirect && (sel[1:0] != 2'b00);
  assign take_trap  = commit && (bus.trap || bad_target);

  // Next-state selection
  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:  state_nxt = FETCH;
      FETCH: begin
        if (bus.stall)     state_nxt = STALL;
        else if (take_trap) state_nxt = TRAP;
      end
      STALL: if (!bus.stall) state_nxt = FETCH;
      TRAP:  state_nxt = FETCH;
      default: state_nxt = BOOT;
    endcase
  end

  // State, PC, saved PC and sticky misalignment flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BOOT;
      pc_q  <= RESET_VECTOR;
      epc_q <= '0;
      mis_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (take_trap) begin
        epc_q <= pc_q;
        pc_q  <= TRAP_VECTOR;
        if (bad_target && !bus.trap) mis_q <= 1'b1;
      end else if (commit) begin
        pc_q <= sel;
      end
    end
  end

  assign bus.imem_req    = (state == FETCH);
  assign bus.fetch_valid = commit;
  assign bus.PC          = pc_q;
  assign bus.PC_next     = sel;
  assign bus.epc         = epc_q;
  assign bus.misaligned  = mis_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Randomized and directed bench for pc_fetch_sequencer with a cycle-level
// reference model of fetch, redirect and trap behaviour.
module tb_pc_fetch_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pc_fetch_if #(.XLEN(32)) bus ();

  pc_fetch_sequencer #(
    .XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  localparam logic [31:0] RV = 32'h0;
  localparam logic [31:0] TV = 32'h100;

  int tests = 0;
  int fails = 0;

  // Reference model: quiet = cycles left with no fetch request (boot/bubble),
  // held = core stalled since the stall began
  logic [31:0] m_pc, m_epc;
  logic        m_mis;
  int          m_quiet;
  bit          m_held;

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_next();
    if (bus.trap)              return TV;
    if (bus.mret)              return m_epc;
    if (bus.jump)              return bus.jump_target;
    if (bus.branch_taken)      return bus.branch_target;
    return m_pc + 32'd4;
  endfunction

  function automatic bit model_req();
    return (m_quiet == 0) && !m_held;
  endfunction

  // Per-cycle compare of every output against the model
  task automatic compare();
    bit req;
    req = model_req();
    chk("imem_req",    {31'b0, bus.imem_req},    {31'b0, req});
    chk("fetch_valid", {31'b0, bus.fetch_valid},
        {31'b0, req && bus.imem_ready && !bus.stall});
    chk("PC",          bus.PC,      m_pc);
    chk("PC_next",     bus.PC_next, model_next());
    chk("epc",         bus.epc,     m_epc);
    chk("misaligned",  {31'b0, bus.misaligned}, {31'b0, m_mis});
  endtask

  task automatic model_step();
    logic [31:0] tgt;
    bit          redir;
    if (rst) begin
      m_pc = RV; m_epc = 0; m_mis = 0; m_quiet = 1; m_held = 0;
    end else if (m_quiet > 0) begin
      m_quiet--;
    end else if (m_held) begin
      if (!bus.stall) m_held = 0;
    end else if (bus.stall) begin
      m_held = 1;
    end else if (bus.imem_ready) begin
      tgt   = model_next();
      redir = !bus.trap && (bus.mret || bus.jump || bus.branch_taken);
      if (bus.trap || (redir && tgt[1:0] != 2'b00)) begin
        m_epc = m_pc;
        m_pc  = TV;
        if (!bus.trap) m_mis = 1;
        m_quiet = 1;
      end else begin
        m_pc = tgt;
      end
    end
  endtask

  // Inputs are already set; compare mid-cycle, then advance model at the edge
  task automatic cycle();
    @(negedge clk);
    compare();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clr();
    bus.stall = 0; bus.branch_taken = 0; bus.jump = 0;
    bus.trap = 0;  bus.mret = 0;
    bus.branch_target = 0; bus.jump_target = 0;
  endtask

  task automatic go_to(logic [31:0] a);
    clr(); bus.imem_ready = 1; bus.jump = 1; bus.jump_target = a;
    cycle(); clr();
  endtask

  initial begin
    m_pc = 0; m_epc = 0; m_mis = 0; m_quiet = 1; m_held = 0;
    clr(); bus.imem_ready = 1; rst = 1;
    @(posedge clk); #1;

    // 1: reset, boot bubble, sequential stepping
    cycle(); cycle(); rst = 0;
    chk("t1_reset_pc", bus.PC, 32'h0);
    chk("t1_boot_req", {31'b0, bus.imem_req}, 32'h0);
    chk("t1_boot_fv",  {31'b0, bus.fetch_valid}, 32'h0);
    cycle();
    chk("t1_fetch_req", {31'b0, bus.imem_req}, 32'h1);
    chk("t1_pc0", bus.PC, 32'h0);
    cycle(); chk("t1_pc4", bus.PC, 32'h4);
    cycle(); chk("t1_pc8", bus.PC, 32'h8);
    cycle(); chk("t1_pcC", bus.PC, 32'hC);

    // 2: jump beats branch
    go_to(32'h8);
    bus.jump = 1; bus.jump_target = 32'h40;
    bus.branch_taken = 1; bus.branch_target = 32'h80;
    #1 chk("t2_pc_next", bus.PC_next, 32'h40);
    cycle(); clr();
    chk("t2_pc", bus.PC, 32'h40);

    // 3: three-cycle stall holds PC
    go_to(32'h10);
    bus.stall = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t3_hold_pc", bus.PC, 32'h10);
      chk("t3_req",     {31'b0, bus.imem_req}, 32'h0);
      chk("t3_fv",      {31'b0, bus.fetch_valid}, 32'h0);
    end
    bus.stall = 0;
    cycle(); chk("t3_resume_req", {31'b0, bus.imem_req}, 32'h1);
    cycle(); chk("t3_pc14", bus.PC, 32'h14);

    // 4: trap entry, bubble, mret return
    go_to(32'h20);
    bus.trap = 1; bus.mret = 1;
    cycle(); clr();
    chk("t4_epc", bus.epc, 32'h20);
    chk("t4_pc",  bus.PC,  32'h100);
    chk("t4_bubble", {31'b0, bus.imem_req}, 32'h0);
    chk("t4_mis", {31'b0, bus.misaligned}, 32'h0);
    cycle();
    bus.mret = 1;
    cycle(); clr();
    chk("t4_mret_pc", bus.PC, 32'h20);

    // 5: misaligned branch traps; PC+4 wraps
    bus.branch_taken = 1; bus.branch_target = 32'h42;
    cycle(); clr();
    chk("t5_mis", {31'b0, bus.misaligned}, 32'h1);
    chk("t5_epc", bus.epc, 32'h20);
    chk("t5_pc",  bus.PC,  32'h100);
    cycle();
    go_to(32'hFFFF_FFFC);
    chk("t5_top", bus.PC, 32'hFFFF_FFFC);
    cycle(); chk("t5_wrap", bus.PC, 32'h0);
    chk("t5_sticky", {31'b0, bus.misaligned}, 32'h1);

    // 6: reset in TRAP and mid-fetch without ready
    bus.trap = 1; cycle(); clr();
    rst = 1; cycle(); rst = 0;
    chk("t6_trap_rst_pc",  bus.PC, 32'h0);
    chk("t6_trap_rst_epc", bus.epc, 32'h0);
    chk("t6_trap_rst_mis", {31'b0, bus.misaligned}, 32'h0);
    cycle();
    go_to(32'h30);
    bus.imem_ready = 0;
    cycle(); chk("t6_wait_pc", bus.PC, 32'h30);
    rst = 1; cycle(); rst = 0;
    chk("t6_fetch_rst_pc",  bus.PC, 32'h0);
    chk("t6_fetch_rst_req", {31'b0, bus.imem_req}, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      rst               = ($urandom_range(0, 199) == 0);
      bus.stall         = ($urandom_range(0, 99) < 20);
      bus.imem_ready    = ($urandom_range(0, 99) < 75);
      bus.trap          = ($urandom_range(0, 99) < 5);
      bus.mret          = ($urandom_range(0, 99) < 6);
      bus.jump          = ($urandom_range(0, 99) < 10);
      bus.branch_taken  = ($urandom_range(0, 99) < 15);
      bus.jump_target   = $urandom() & 32'hFFFF_FFFC;
      bus.branch_target = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(0, 9) == 0) bus.jump_target   = bus.jump_target | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 9) == 0) bus.branch_target = bus.branch_target | 32'($urandom_range(1, 3));
      cycle();
    end
    rst = 0; clr();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
